aes_decrypt: RTL
================

# aes_decrypt

Iterative AES-128 inverse cipher (FIPS-197): takes a 128-bit ciphertext and key, expands the key schedule internally, and returns the plaintext after a fixed number of clocks. It is the receive-side counterpart of the encryption datapath. It shares that datapath's byte/state conventions, so ciphertext from the encryptor feeds it directly and round-trips to the original plaintext. One inverse round is computed per clock; no external S-box module is required.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- i_clock  in  1  single clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in s_IDLE.
- i_cipher  in  [0:127]  ciphertext; byte n = bits [8n:8n+7], state row n%4, column n/4.
- i_key  in  [0:127]  cipher key, same byte ordering.
- o_plain  out  [0:127]  plaintext result, same byte ordering; registered.
- o_valid  out  1  one-cycle pulse: o_plain holds a new result.
- o_busy  out  1  high in every state except s_IDLE.

## Operation
- States: s_IDLE, s_KEY_EXPAND, s_INIT_ROUND, s_ROUND, s_FINAL, s_DONE.
- s_IDLE: on i_start=1, latch i_cipher into state register and i_key into rk[0]; clear round counter; go s_KEY_EXPAND. i_start=0: stay.
- s_KEY_EXPAND: one round key per clock, rk[i] = f(rk[i-1], Rcon[i]) for i=1..10. Rcon = 01,02,04,08,10,20,40,80,1b,36. f = RotWord, SubWord, XOR Rcon, then chained XOR of words 1..3. After rk[10] is written, go s_INIT_ROUND.
- s_INIT_ROUND: state ^= rk[10]; round counter = 9; go s_ROUND.
- s_ROUND (r = 9 down to 1): state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]); decrement r; after r=1 go s_FINAL.
- s_FINAL: o_plain <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; go s_DONE.
- s_DONE: o_valid=1 for this cycle only; go s_IDLE.
- InvShiftRows: row k rotated right by k bytes.
- InvMixColumns: matrix {0e,0b,0d,09} circulant over GF(2^8) mod x^8+x^4+x^3+x+1.
- S-box and inverse S-box are computed from GF(2^8) multiplicative inverse (0 maps to 0) plus the FIPS affine transform or its inverse. A ROM-free implementation is required.
- i_start while o_busy=1 is ignored; i_cipher/i_key are not re-sampled mid-operation.
- o_plain holds its last value until the next s_FINAL or reset.

## Timing
- Reset: state -> s_IDLE, o_plain=0, o_valid=0, o_busy=0, round counter=0, rk array need not be cleared.
- Reset asserted in any state aborts the operation at that edge; no o_valid is produced for the aborted block.
- Reset has priority over i_start on the same edge.
- Edge E0 samples i_start=1. Edges E1–E10 write rk[1..10]. E11 applies the initial AddRoundKey. E12–E20 run the 9 full rounds. E21 registers o_plain. o_valid is high during the cycle after E21.
- Latency: 22 clocks from start edge to o_valid high. o_busy is high from E0+ through the o_valid cycle.
- Back-to-back: i_start may be high in the cycle after o_valid (s_IDLE). Minimum issue interval is 23 clocks.
- o_valid never asserts twice without an intervening accepted i_start.

## Test plan
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> o_plain 3243f6a8885a308d313198a2e0370734, o_valid exactly 22 clocks after start. Internal rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> o_plain 00112233445566778899aabbccddeeff.
- All-zero key, cipher 66e94bd4ef8a2c3b884cfa59ca342b2e -> o_plain all zeros. o_busy and o_valid toggle as specified.
- i_start held high continuously with vector B, then C.1 loaded after the first o_valid. Required: two results, 23 clocks apart, correct in order. i_cipher changes mid-operation do not affect the result.
- i_reset asserted at clock 15 of an operation -> o_plain=0, o_valid never pulses, o_busy=0 next cycle. A fresh start then yields the correct result.
- Round trip: encryptor output for random plaintext/key pairs (≥100) fed to this block -> o_plain equals the original plaintext.

Source files
------------

// File: rtl/aes_decrypt.sv
// -----------------------------------------------------------------------------
// aes_decrypt
// Iterative AES-128 inverse cipher. The block loads a ciphertext and a cipher
// key, expands all eleven round keys into a small register file (one key per
// clock), and then runs the inverse rounds, one per clock. The byte/state
// layout is the same as the encryption datapath's, so its ciphertext can be
// fed straight in.
//
// S-box and inverse S-box are built from GF(2^8) arithmetic: a multiplicative
// inverse, computed as x^254, plus the FIPS affine map or its inverse. There
// are no lookup tables.
//
// Ports
//   i_clock   : single clock, rising edge
//   i_reset   : synchronous, active-high reset
//   i_start   : start request, only honoured while idle
//   i_cipher  : [0:127] ciphertext, byte n = bits [8n:8n+7],
//               state row n%4, column n/4
//   i_key     : [0:127] cipher key, same byte ordering
//   o_plain   : [0:127] registered plaintext; holds until the next result
//   o_valid   : one-cycle pulse when o_plain carries a new result
//   o_busy    : high in every state except idle
// -----------------------------------------------------------------------------
module aes_decrypt (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [0:127] i_cipher,
   input  logic [0:127] i_key,
   output logic [0:127] o_plain,
   output logic         o_valid,
   output logic         o_busy
);

   typedef enum logic [2:0] {
      s_IDLE,
      s_KEY_EXPAND,
      s_INIT_ROUND,
      s_ROUND,
      s_FINAL,
      s_DONE
   } state_t;

   // --------------------------------------------------------------------------
   // GF(2^8) helpers, modulus x^8 + x^4 + x^3 + x + 1
   // --------------------------------------------------------------------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Inverse as a^254 = a^2 * a^4 * ... * a^128. Zero naturally maps to zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = a;
      res = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   // Forward S-box: inverse, then affine b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 63.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Inverse S-box: inverse affine (rotl1 ^ rotl3 ^ rotl6 ^ 05), then inverse.
   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   // Round constant used when producing rk[idx+1].
   function automatic logic [7:0] rcon_of(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   state_t       state_reg, state_next;
   logic [0:127] data_reg,  data_next;
   logic [0:127] plain_reg, plain_next;
   logic [3:0]   rnd_reg,   rnd_next;

   // Round-key file. Entry 0 is the cipher key, entry 10 the last round key.
   logic [0:127] rk_mem [0:10];
   logic         rk_we;
   logic [3:0]   rk_waddr;
   logic [0:127] rk_wdata;
   logic [0:127] rk_cur;

   // The round counter doubles as the key-file read address in every phase:
   // it walks 0..9 during expansion (reading the previous key), sits at 10
   // for the initial AddRoundKey, 9..1 for the full rounds and 0 for the
   // final round, so a single read port suffices.
   assign rk_cur = rk_mem[rnd_reg];

   // --------------------------------------------------------------------------
   // Key expansion step: next round key from rk_cur and Rcon
   // --------------------------------------------------------------------------
   logic [31:0]  kw0, kw1, kw2, kw3;
   logic [31:0]  rot_w, sub_w;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic [0:127] key_exp;

   assign kw0   = rk_cur[0  +: 32];
   assign kw1   = rk_cur[32 +: 32];
   assign kw2   = rk_cur[64 +: 32];
   assign kw3   = rk_cur[96 +: 32];
   assign rot_w = {kw3[23:0], kw3[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_subword
         assign sub_w[8*gi +: 8] = sbox_fwd(rot_w[8*gi +: 8]);
      end
   endgenerate

   assign nw0     = kw0 ^ sub_w ^ {rcon_of(rnd_reg), 24'h000000};
   assign nw1     = kw1 ^ nw0;
   assign nw2     = kw2 ^ nw1;
   assign nw3     = kw3 ^ nw2;
   assign key_exp = {nw0, nw1, nw2, nw3};

   // --------------------------------------------------------------------------
   // Inverse round datapath
   // isb_ark = InvSubBytes(InvShiftRows(state)) ^ rk_cur, which is the whole
   // final round when rk_cur is rk[0]; inv_mix adds InvMixColumns on top.
   // --------------------------------------------------------------------------
   logic [0:127] isb_ark;
   logic [0:127] inv_mix;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_isr
         // Row r rotates right by r, so output column c takes column c-r.
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
         assign isb_ark[8*gi +: 8] = sbox_inv(data_reg[8*SRC +: 8]) ^ rk_cur[8*gi +: 8];
      end

      for (gi = 0; gi < 4; gi++) begin : g_imc
         logic [7:0] a0, a1, a2, a3;
         assign a0 = isb_ark[32*gi      +: 8];
         assign a1 = isb_ark[32*gi + 8  +: 8];
         assign a2 = isb_ark[32*gi + 16 +: 8];
         assign a3 = isb_ark[32*gi + 24 +: 8];
         assign inv_mix[32*gi      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                         ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         assign inv_mix[32*gi + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                         ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         assign inv_mix[32*gi + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                         ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         assign inv_mix[32*gi + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                         ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Control: next-state and datapath selection
   // --------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      plain_next = plain_reg;
      rnd_next   = rnd_reg;
      rk_we      = 1'b0;
      rk_waddr   = rnd_reg + 4'd1;
      rk_wdata   = key_exp;

      case (state_reg)
         s_IDLE: begin
            if (i_start) begin
               data_next  = i_cipher;
               rk_we      = 1'b1;
               rk_waddr   = 4'd0;
               rk_wdata   = i_key;
               rnd_next   = 4'd0;
               state_next = s_KEY_EXPAND;
            end
         end
         s_KEY_EXPAND: begin
            rk_we    = 1'b1;
            rnd_next = rnd_reg + 4'd1;
            if (rnd_reg == 4'd9) state_next = s_INIT_ROUND;
         end
         s_INIT_ROUND: begin
            data_next  = data_reg ^ rk_cur;
            rnd_next   = 4'd9;
            state_next = s_ROUND;
         end
         s_ROUND: begin
            data_next = inv_mix;
            rnd_next  = rnd_reg - 4'd1;
            if (rnd_reg == 4'd1) state_next = s_FINAL;
         end
         s_FINAL: begin
            plain_next = isb_ark;
            state_next = s_DONE;
         end
         s_DONE: begin
            state_next = s_IDLE;
         end
         default: begin
            state_next = s_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_reg <= s_IDLE;
         data_reg  <= '0;
         plain_reg <= '0;
         rnd_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         plain_reg <= plain_next;
         rnd_reg   <= rnd_next;
      end
   end

   // The key file carries no reset: every entry is rewritten before use.
   always_ff @(posedge i_clock) begin
      if (rk_we) rk_mem[rk_waddr] <= rk_wdata;
   end

   assign o_plain = plain_reg;
   assign o_valid = (state_reg == s_DONE);
   assign o_busy  = (state_reg != s_IDLE);

endmodule
